// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3).
// Each operand takes W clock cycles. Handshaking is valid/ready on both sides.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand; in_ready high
// SHIFT | one correct-and-shift step per cycle, counter counts W down to 0
// DONE  | result held on bcd with out_valid high until out_ready
module bin2bcd_serial #(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*ND-1:0] bcd
);

  // The counter must be able to hold the value W itself, not just W-1.
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [W-1:0]       sr;
  logic [4*ND-1:0]    acc;
  logic [4*ND-1:0]    acc_adj;
  logic [CW-1:0]      cnt;
  logic [4*ND+W-1:0]  shifted;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. The last step is the one that takes the counter from 1 to 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)          state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1))     state_nxt = DONE;
      DONE:    if (out_ready)         state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Add 3 to any digit of 5 or more, so that after the shift it carries
  // correctly into the next decimal digit.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < ND; k++) begin
      if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
    end
  end

  // The top bit is lost in the shift. The ND parameter is only legal when
  // that bit is always zero.
  assign shifted = {acc_adj, sr} << 1;

  // Datapath: capture the operand, then do one correct-and-shift step per cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sr  <= bin;
            acc <= '0;
            cnt <= CW'(W);
          end
        end
        SHIFT: begin
          acc <= shifted[4*ND+W-1:W];
          sr  <= shifted[W-1:0];
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign bcd       = acc;

endmodule

// File: doc/bin2bcd_serial.md
BIN2BCD_SERIAL -- requirements
Module: bin2bcd_serial

Interface
REQ-001 SHALL have parameter W, default 8, meaning the binary input width in bits.
REQ-002 SHALL have parameter ND, default 3, meaning the number of BCD output digits; legal only when 10^ND > 2^W - 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  binary operand on bin is offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port bin  input  W  unsigned binary operand.
REQ-008 SHALL have port out_valid  output  1  conversion result on bcd is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port bcd  output  4*ND  packed BCD result, digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready high exactly when state is IDLE; it SHALL NOT depend combinationally on any input.
REQ-013 In IDLE, on a rising edge with in_valid=1, SHALL capture bin into an internal W-bit shift register, clear the BCD accumulator to 0, load the step counter with W, and enter SHIFT.
REQ-014 In IDLE with in_valid=0, SHALL hold all state.
REQ-015 In SHIFT, each edge SHALL first add 3 to every accumulator digit whose value is >= 5, then shift {accumulator, shift register} left by one bit, then decrement the step counter.
REQ-016 The add-3 correction and the shift SHALL complete in one cycle; no accumulator digit SHALL ever hold a value above 9 after a shift.
REQ-017 When the step counter reaches 0, SHALL enter DONE; the accept edge is E0, and out_valid SHALL be high from edge E0+W onward (total latency W cycles).
REQ-018 In DONE, SHALL hold out_valid=1 and keep bcd unchanged while out_ready=0.
REQ-019 In DONE, on an edge with out_ready=1, SHALL enter IDLE and deassert out_valid; a new operand is accepted no earlier than the following edge.
REQ-020 SHALL ignore in_valid and changes on bin in SHIFT and DONE.
REQ-021 bcd SHALL be driven from the accumulator register at all times; its value is defined only while out_valid=1.
REQ-022 bcd SHALL equal the exact decimal value of the captured operand, leading digits zero. Examples: 255 gives 0x255; 0 gives 0x000.
REQ-023 The step counter SHALL be wide enough to hold W.

Reset
REQ-024 While nrst=0, SHALL asynchronously force state=IDLE, accumulator=0, shift register=0 and counter=0.
REQ-025 Reset values SHALL be out_valid=0, bcd=0 and in_ready=1.
REQ-026 SHALL accept no operand while nrst=0.
REQ-027 Reset asserted in SHIFT or DONE SHALL abandon the conversion with no result emitted; the first accept is possible on the first edge after nrst rises.

Verification
REQ-028 Drive bin=255 with in_valid=1 for one accept edge, out_ready=1 -> out_valid rises exactly 8 cycles after accept with bcd=0x255, and in_ready returns high one cycle later.
REQ-029 Drive bin=0 -> out_valid after 8 cycles with bcd=0x000; drive bin=99 -> bcd=0x099; drive bin=100 -> bcd=0x100.
REQ-030 Drive bin=137, hold out_ready=0 for 5 cycles after out_valid -> bcd stays 0x137 and out_valid stays 1 throughout; in_ready stays 0; one cycle with out_ready=1 -> IDLE.
REQ-031 Accept bin=42, then change bin to 200 with in_valid=1 during SHIFT -> result is 0x042, and 200 is accepted only once state is back in IDLE.
REQ-032 Assert nrst=0 for 1 cycle at step 4 of a conversion of bin=201 -> out_valid=0, bcd=0, in_ready=1 immediately; a subsequent bin=201 yields 0x201 after 8 cycles.
REQ-033 Exhaustive sweep bin=0..255 with random out_ready backpressure -> every result matches the decimal reference model, and no result is dropped or duplicated.
